spi_adc_responder: RTL and testbench

//   SPI responder (slave) emulating the 12-bit serial ADC read by our SPI master; the far end of the same MISO/MOSI/SCK/CS link.

---
 rtl/spi_rsp_pkg.sv | 21 ++
 rtl/spi_rsp_sync_edge.sv | 25 ++
 rtl/spi_adc_responder.sv | 190 +++++++++++++++++++
 tb/tb_spi_adc_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rsp_pkg.sv
// Shared types and defaults for the SPI ADC responder.
package spi_rsp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_DATA_W      = 12;
    localparam int unsigned DEF_FRAME_BITS  = 16;
    localparam int unsigned DEF_LEAD_ZEROS  = 3;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Width needed to count 0..n inclusive
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_rsp_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input with rise/fall strobes.
// The chain has no reset so it keeps tracking the pin while rst_n is low and no false edge appears at reset exit.
module spi_rsp_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              level;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[STAGES-2:0], din};
        prev_q <= sync_q[STAGES-1];
    end

    assign level  = sync_q[STAGES-1];
    assign rise_c = level & ~prev_q;
    assign fall_c = ~level & prev_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder emulating a 12-bit serial ADC: latches a fabric sample and shifts it out on MISO.
// Optional MOSI capture is enabled with `define SPI_RSP_MOSI_CAPTURE_EN.
module spi_adc_responder
    import spi_rsp_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned FRAME_BITS  = DEF_FRAME_BITS,
    parameter int unsigned LEAD_ZEROS  = DEF_LEAD_ZEROS,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_W-1:0]     sample_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic                  underrun,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid
);

    localparam int unsigned TRAIL_BITS = FRAME_BITS - LEAD_ZEROS - DATA_W;
    localparam int unsigned CNT_W      = cnt_width(FRAME_BITS);

    if (LEAD_ZEROS + DATA_W > FRAME_BITS) begin : g_bad_frame
        $error("spi_adc_responder: LEAD_ZEROS + DATA_W exceeds FRAME_BITS");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("spi_adc_responder: SYNC_STAGES must be at least 2");
    end

    state_e                  state;
    logic [FRAME_BITS-2:0]   shreg;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_W-1:0]       hold;
    logic                    hold_valid;
    logic [DATA_W-1:0]       last_sent;
    logic [DATA_W-1:0]       load_src;
    logic [FRAME_BITS-1:0]   frame_word;
    logic                    accept;
    logic                    sck_rise;
    logic                    sck_fall;
    logic                    cs_rise;
    logic                    cs_fall;

    spi_rsp_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk    (clk),
        .din    (sck),
        .rise_c (sck_rise),
        .fall_c (sck_fall)
    );

    spi_rsp_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk    (clk),
        .din    (cs_n),
        .rise_c (cs_rise),
        .fall_c (cs_fall)
    );

    assign sample_ready = !hold_valid || (state == LOAD);
    assign accept       = sample_valid && sample_ready;
    assign miso_oe      = (state != IDLE);
    assign load_src     = hold_valid ? hold : last_sent;
    assign frame_word   = FRAME_BITS'(load_src) << TRAIL_BITS;

    // Frame sequencer; shreg holds the bits still to follow the one on miso
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            miso        <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            hold        <= '0;
            hold_valid  <= 1'b0;
            last_sent   <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            underrun    <= 1'b0;

            if (accept && state != LOAD) begin
                hold       <= sample_data;
                hold_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    miso    <= 1'b0;
                    bit_cnt <= '0;
                    if (cs_fall) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // Frame uses the sample held now; a same-cycle accept refills hold for the next frame
                    shreg      <= frame_word[FRAME_BITS-2:0];
                    bit_cnt    <= '0;
                    hold_valid <= accept;
                    if (accept) begin
                        hold <= sample_data;
                    end
                    if (hold_valid) begin
                        last_sent <= hold;
                    end else begin
                        underrun <= 1'b1;
                    end
                    if (cs_rise) begin
                        frame_abort <= 1'b1;
                        miso        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        miso  <= frame_word[FRAME_BITS-1];
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        frame_abort <= 1'b1;
                        miso        <= 1'b0;
                        state       <= IDLE;
                    end else if (sck_rise) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            frame_done <= 1'b1;
                            miso       <= 1'b0;
                            state      <= DONE;
                        end
                    end else if (sck_fall) begin
                        miso  <= shreg[FRAME_BITS-2];
                        shreg <= {shreg[FRAME_BITS-3:0], 1'b0};
                    end
                end
                DONE: begin
                    miso <= 1'b0;
                    if (cs_rise) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    miso  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_RSP_MOSI_CAPTURE_EN
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;
    logic [FRAME_BITS-2:0]  rx_shreg;

    // Same depth as the sck chain so mosi_s lines up with sck_rise
    always_ff @(posedge clk) begin
        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_shreg <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == SHIFT && !cs_rise && sck_rise) begin
                rx_shreg <= {rx_shreg[FRAME_BITS-3:0], mosi_s};
                if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                    rx_data  <= {rx_shreg, mosi_s};
                    rx_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_mosi;
    assign unused_mosi = mosi;
    assign rx_data     = '0;
    assign rx_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: a mode-0 master model driven from a vector table plus reset corner cases.
module tb_spi_adc_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic [11:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        frame_done;
    logic        frame_abort;
    logic        underrun;
    logic [15:0] rx_data;
    logic        rx_valid;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_abort = 0;
    int n_under = 0;
    int n_rxv = 0;

    spi_adc_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sck          (sck),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .underrun     (underrun),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)  n_done++;
        if (frame_abort) n_abort++;
        if (underrun)    n_under++;
        if (rx_valid)    n_rxv++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [11:0] d);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        sample_data  = d;
        sample_valid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (sample_ready) begin
                @(posedge clk); #1;
                sample_valid = 1'b0;
                got = 1'b1;
            end
        end
        sample_valid = 1'b0;
        check("push_accept", 32'(got), 32'd1);
    endtask

    task automatic run_frame(input int nedges, input logic [15:0] tx, input logic lp,
                             input logic [11:0] lps, output logic [15:0] rd,
                             output logic extra, output logic oe_mid);
        logic got;
        rd    = '0;
        extra = 1'b0;
        @(posedge clk); #1;
        if (lp) begin
            sample_data  = lps;
            sample_valid = 1'b1;
        end
        cs_n = 1'b0;
        if (lp) begin
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (sample_ready) begin
                    @(posedge clk); #1;
                    sample_valid = 1'b0;
                    got = 1'b1;
                end
            end
            sample_valid = 1'b0;
            check("load_push_accept", 32'(got), 32'd1);
        end
        repeat (8) @(posedge clk);
        #1;
        oe_mid = miso_oe;
        for (int i = 0; i < nedges; i++) begin
            mosi = (i < 16) ? tx[15-i] : 1'b0;
            repeat (5) @(posedge clk);
            #1;
            sck = 1'b1;
            if (i < 16) rd[15-i] = miso;
            else        extra = extra | miso;
            repeat (5) @(posedge clk);
            #1;
            sck = 1'b0;
        end
        repeat (5) @(posedge clk);
        #1;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        push_en;
        logic [11:0] sample;
        logic        load_push;
        logic [11:0] load_sample;
        int          nedges;
        logic [15:0] tx;
        logic [15:0] exp_word;
        int          exp_done;
        int          exp_abort;
        int          exp_under;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [15:0] rd;
        logic        extra;
        logic        oe_mid;
        logic [15:0] exp_rx;
        int d0, a0, u0, r0;

        vecs[0] = '{1'b1, 12'hABC, 1'b0, 12'h000, 16, 16'hC3A5, 16'h1578, 1, 0, 0, 1'b1};
        vecs[1] = '{1'b0, 12'h000, 1'b0, 12'h000, 16, 16'h5A0F, 16'h1578, 1, 0, 1, 1'b1};
        vecs[2] = '{1'b0, 12'h000, 1'b0, 12'h000,  7, 16'hFFFF, 16'h0000, 0, 1, 1, 1'b1};
        vecs[3] = '{1'b1, 12'h123, 1'b0, 12'h000, 16, 16'h0001, 16'h0246, 1, 0, 0, 1'b1};
        vecs[4] = '{1'b1, 12'hABC, 1'b1, 12'h555, 16, 16'h8000, 16'h1578, 1, 0, 0, 1'b0};
        vecs[5] = '{1'b0, 12'h000, 1'b0, 12'h000, 16, 16'h1234, 16'h0AAA, 1, 0, 0, 1'b1};
        vecs[6] = '{1'b1, 12'h3C1, 1'b0, 12'h000, 20, 16'hA5C3, 16'h0782, 1, 0, 0, 1'b1};
        vecs[7] = '{1'b1, 12'hFFF, 1'b0, 12'h000, 16, 16'hFFFF, 16'h1FFE, 1, 0, 0, 1'b1};
        exp_rx = 16'h0000;

        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_miso_oe", 32'(miso_oe), 32'd0);
        check("reset_ready", 32'(sample_ready), 32'd1);
        check("reset_pulses", 32'({frame_done, frame_abort, underrun, rx_valid}), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].push_en) push(vecs[v].sample);
            d0 = n_done; a0 = n_abort; u0 = n_under; r0 = n_rxv;
            run_frame(vecs[v].nedges, vecs[v].tx, vecs[v].load_push, vecs[v].load_sample,
                      rd, extra, oe_mid);
            check($sformatf("v%0d_oe_mid", v), 32'(oe_mid), 32'd1);
            if (vecs[v].exp_done == 1) begin
                check($sformatf("v%0d_word", v), 32'(rd), 32'(vecs[v].exp_word));
            end
            if (vecs[v].nedges > 16) begin
                check($sformatf("v%0d_after_done_miso", v), 32'(extra), 32'd0);
            end
            check($sformatf("v%0d_done", v), 32'(n_done - d0), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_abort", v), 32'(n_abort - a0), 32'(vecs[v].exp_abort));
            check($sformatf("v%0d_underrun", v), 32'(n_under - u0), 32'(vecs[v].exp_under));
            check($sformatf("v%0d_ready", v), 32'(sample_ready), 32'(vecs[v].exp_ready));
            check($sformatf("v%0d_oe_after", v), 32'(miso_oe), 32'd0);
`ifdef SPI_RSP_MOSI_CAPTURE_EN
            if (vecs[v].exp_done == 1) exp_rx = vecs[v].tx;
            check($sformatf("v%0d_rx_valid", v), 32'(n_rxv - r0), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_rx_data", v), 32'(rx_data), 32'(exp_rx));
`else
            check($sformatf("v%0d_rx_valid", v), 32'(n_rxv - r0), 32'd0);
            check($sformatf("v%0d_rx_data", v), 32'(rx_data), 32'(exp_rx));
`endif
        end

        // Reset in the middle of a frame, with a sample pending
        push(12'h7E7);
        @(posedge clk); #1;
        cs_n = 1'b0;
        repeat (8) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            mosi = ~mosi;
            repeat (5) @(posedge clk);
            #1;
            sck = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            sck = 1'b0;
        end
        check("mid_frame_oe", 32'(miso_oe), 32'd1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mid_miso", 32'(miso), 32'd0);
        check("rst_mid_oe", 32'(miso_oe), 32'd0);
        check("rst_mid_ready", 32'(sample_ready), 32'd1);
        check("rst_mid_pulses", 32'({frame_done, frame_abort, underrun, rx_valid}), 32'd0);
        check("rst_mid_rx_data", 32'(rx_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        d0 = n_done; a0 = n_abort; u0 = n_under;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_no_frame_oe", 32'(miso_oe), 32'd0);
        check("post_rst_no_pulses", 32'((n_done - d0) + (n_abort - a0) + (n_under - u0)), 32'd0);
        cs_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Fresh frame after reset: hold empty and last_sent cleared
        d0 = n_done; u0 = n_under;
        run_frame(16, 16'h0F0F, 1'b0, 12'h000, rd, extra, oe_mid);
        check("post_rst_word", 32'(rd), 32'h0000);
        check("post_rst_done", 32'(n_done - d0), 32'd1);
        check("post_rst_underrun", 32'(n_under - u0), 32'd1);
        check("post_rst_oe_mid", 32'(oe_mid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
